cache_assoc: RTL and testbench

CACHE_ASSOC -- requirements
Module: cache_assoc

---
 rtl/cache_assoc.sv | 192 +++++++++++++++++++
 tb/tb_cache_assoc.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc.sv
// Set-associative, write-through, no-write-allocate cache with one word per block.
//
// Loads that hit finish in the same cycle. Loads that miss fetch the word from memory
// in READ_MISS, return it to the CPU in the acknowledge cycle and fill a victim way.
// Stores always go to memory through WRITE_THRU. A store that hits also updates the
// cached word. A store that misses does not allocate a line.
//
// Ports:
//   clk_i, rst_i                  clock and synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU request, held until cpu_ready_o
//   cpu_rdata_o, cpu_ready_o      load data and completion strobe
//   flush_i                       invalidate every line (taken only in IDLE)
//   mem_req_o/we_o/addr_o/wdata_o memory request, held until mem_ack_i
//   mem_rdata_i, mem_ack_i        memory response
//   hit_count_o, miss_count_o     load hit/miss counters, wrapping
module cache_assoc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SET_BITS   = 10,
  parameter int unsigned WAYS       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [DATA_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_ready_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [DATA_WIDTH-1:0] hit_count_o,
  output logic [DATA_WIDTH-1:0] miss_count_o
);

  localparam int unsigned SETS      = 1 << SET_BITS;
  localparam int unsigned TAG_WIDTH = DATA_WIDTH - SET_BITS - 2;
  // The replacement pointer is kept 1 bit wide for direct-mapped, but it stays at 0.
  localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StReadMiss, StWriteThru} state_e;

  state_e                state_q;
  logic                  mem_req_q, mem_we_q;
  logic [DATA_WIDTH-1:0] hit_count_q, miss_count_q;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAY_BITS-1:0]   ptr_q   [SETS];
  logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

  logic [SET_BITS-1:0]   set_idx;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic                  has_invalid;
  logic [WAY_BITS-1:0]   victim_way;
  logic                  fill_en, store_en;

  // Bits [1:0] select a byte inside the word, and the cache does not use them.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign set_idx = cpu_addr_i[SET_BITS+1:2];
  assign req_tag = cpu_addr_i[DATA_WIDTH-1:SET_BITS+2];

  // Tag lookup. Tags in a set are kept unique, so at most one way can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // Victim choice: the lowest-index invalid way if one exists, otherwise the way
  // at the replacement pointer. The loop runs downward so the lowest index is kept.
  always_comb begin
    has_invalid = 1'b0;
    victim_way  = (WAYS > 1) ? ptr_q[set_idx] : '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) begin
        has_invalid = 1'b1;
        victim_way  = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    cpu_ready_o = 1'b0;
    cpu_rdata_o = data_q[set_idx][hit_way];
    case (state_q)
      StIdle:      cpu_ready_o = cpu_req_i & ~flush_i & ~cpu_we_i & hit;
      StReadMiss: begin
        cpu_ready_o = cpu_req_i & mem_ack_i;
        cpu_rdata_o = mem_rdata_i;
      end
      StWriteThru: cpu_ready_o = cpu_req_i & mem_ack_i;
      default:     cpu_ready_o = 1'b0;
    endcase
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = {cpu_addr_i[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata_o  = cpu_wdata_i;
  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;

  // Control FSM, valid bits, replacement pointers and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (flush_i) begin
            for (int s = 0; s < int'(SETS); s++) begin
              valid_q[s] <= '0;
              ptr_q[s]   <= '0;
            end
          end else if (cpu_req_i) begin
            if (cpu_we_i) begin
              state_q   <= StWriteThru;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
            end else if (hit) begin
              hit_count_q <= hit_count_q + 1'b1;
            end else begin
              miss_count_q <= miss_count_q + 1'b1;
              state_q      <= StReadMiss;
              mem_req_q    <= 1'b1;
              mem_we_q     <= 1'b0;
            end
          end
        end
        StReadMiss: begin
          if (mem_ack_i) begin
            valid_q[set_idx][victim_way] <= 1'b1;
            // The pointer moves only when a valid line was evicted.
            if ((WAYS > 1) && !has_invalid) begin
              ptr_q[set_idx] <= ptr_q[set_idx] + WAY_BITS'(1);
            end
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end
        end
        StWriteThru: begin
          if (mem_ack_i) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fill_en  = ~rst_i & (state_q == StReadMiss) & mem_ack_i;
  assign store_en = ~rst_i & (state_q == StWriteThru) & mem_ack_i & hit;

  // Tag and data arrays have no reset. The valid bits alone decide whether a hit occurs.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[set_idx][victim_way]  <= req_tag;
      data_q[set_idx][victim_way] <= mem_rdata_i;
    end else if (store_en) begin
      data_q[set_idx][hit_way] <= cpu_wdata_i;
    end
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc. A reference model checks the DUT on every cycle:
// it tracks which tags each set holds and which memory words exist, and returns
// load data from memory, which a write-through cache must match. Directed
// sequences with fixed expected values come first, then randomized traffic.
module tb_cache_assoc;
  localparam int DW    = 32;
  localparam int SB    = 10;
  localparam int NW    = 2;
  localparam int TW    = DW - SB - 2;
  localparam int NSETS = 1 << SB;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, cpu_we_i, flush_i, mem_ack_i;
  logic [DW-1:0] cpu_addr_i, cpu_wdata_i, mem_rdata_i;
  logic [DW-1:0] cpu_rdata_o, mem_addr_o, mem_wdata_o, hit_count_o, miss_count_o;
  logic          cpu_ready_o, mem_req_o, mem_we_o;

  always #5 clk_i = ~clk_i;

  cache_assoc #(
    .DATA_WIDTH(DW),
    .SET_BITS  (SB),
    .WAYS      (NW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_ready_o (cpu_ready_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .hit_count_o (hit_count_o),
    .miss_count_o(miss_count_o)
  );

  // Reference model state
  bit             mvalid [NSETS][NW];
  logic [TW-1:0]  mtag   [NSETS][NW];
  int             mptr   [NSETS];
  int             mbusy;             // 0 none outstanding, 1 load fetch, 2 store
  logic [31:0]    mhit, mmiss;
  logic [31:0]    mem_m [logic [29:0]];

  int unsigned    vectors, miscompares;
  bit             s_ready, s_memreq, s_memwe;
  logic [31:0]    s_rdata, s_memwdata;
  int             lat_g, wait_cnt;

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return ({wa, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(1, 4)) << 12) | (32'($urandom_range(0, 3)) << 2) |
        32'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NSETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < NW; w++) mvalid[s][w] = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model, sampled between clock edges.
  always @(negedge clk_i) begin
    int            sidx, hw, vic;
    logic [TW-1:0] tg;
    bit            exp_ready;
    sidx = int'(cpu_addr_i[SB+1:2]);
    tg   = cpu_addr_i[DW-1:SB+2];
    hw   = -1;
    for (int w = 0; w < NW; w++) if (mvalid[sidx][w] && mtag[sidx][w] == tg) hw = w;
    chk("hit_count", hit_count_o, mhit);
    chk("miss_count", miss_count_o, mmiss);
    s_ready    = cpu_ready_o;
    s_rdata    = cpu_rdata_o;
    s_memreq   = mem_req_o;
    s_memwe    = mem_we_o;
    s_memwdata = mem_wdata_o;
    if (rst_i) begin
      model_clear();
      mbusy = 0;
      mhit  = '0;
      mmiss = '0;
    end else begin
      exp_ready = 1'b0;
      chk("mem_req", 32'(mem_req_o), 32'(mbusy != 0));
      chk("mem_we", 32'(mem_we_o), 32'(mbusy == 2));
      if (mbusy != 0) chk("mem_addr", mem_addr_o, {cpu_addr_i[31:2], 2'b00});
      if (mbusy == 2) chk("mem_wdata", mem_wdata_o, cpu_wdata_i);
      case (mbusy)
        0: begin
          if (flush_i) model_clear();
          else if (cpu_req_i) begin
            if (cpu_we_i) mbusy = 2;
            else if (hw >= 0) begin
              exp_ready = 1'b1;
              mhit++;
            end else begin
              mmiss++;
              mbusy = 1;
            end
          end
        end
        1: if (mem_ack_i) begin
          exp_ready = 1'b1;
          vic = -1;
          for (int w = 0; w < NW; w++) if (!mvalid[sidx][w] && vic < 0) vic = w;
          if (vic < 0) begin
            vic = mptr[sidx];
            mptr[sidx] = (mptr[sidx] + 1) % NW;
          end
          mvalid[sidx][vic] = 1'b1;
          mtag[sidx][vic]   = tg;
          mbusy = 0;
        end
        default: if (mem_ack_i) begin
          exp_ready = 1'b1;
          mem_m[cpu_addr_i[31:2]] = cpu_wdata_i;
          mbusy = 0;
        end
      endcase
      chk("cpu_ready", 32'(cpu_ready_o), 32'(exp_ready & cpu_req_i));
      if (exp_ready && cpu_req_i && !cpu_we_i)
        chk("cpu_rdata", cpu_rdata_o, mem_rd(cpu_addr_i[31:2]));
    end
  end

  // Advance one cycle. The memory responder acks after lat_g request cycles.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (mem_req_o && !rst_i) begin
      wait_cnt++;
      if (wait_cnt >= lat_g) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_rd(mem_addr_o[31:2]);
        wait_cnt    = 0;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
      end
    end else begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      wait_cnt    = 0;
    end
  endtask

  task automatic set_rst(input bit v);
    rst_i = v;
    if (v) mem_ack_i = 1'b0;
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input int fl_pct,
                        output logic [31:0] rd, output int reqcyc);
    bit done;
    done        = 1'b0;
    lat_g       = lat;
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    flush_i     = 1'b0;
    reqcyc      = 0;
    rd          = '0;
    for (int n = 0; n < 80 && !done; n++) begin
      step();
      if (s_memreq) reqcyc++;
      if (s_ready) begin
        done = 1'b1;
        rd   = s_rdata;
      end else begin
        flush_i = ($urandom_range(0, 99) < fl_pct);
      end
    end
    cpu_req_i = 1'b0;
    flush_i   = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL access_timeout: addr 0x%08h got no cpu_ready, required within 80 cycles",
               addr);
    end
  endtask

  task automatic do_reset();
    set_rst(1'b1);
    step();
    step();
    set_rst(1'b0);
  endtask

  logic [31:0] rd;
  int          rc;
  logic [31:0] h0, m0;

  initial begin
    vectors = 0; miscompares = 0; mbusy = 0; mhit = '0; mmiss = '0;
    lat_g = 1; wait_cnt = 0;
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    cpu_addr_i = '0; cpu_wdata_i = '0; mem_rdata_i = '0;
    model_clear();
    step();
    step();
    set_rst(1'b0);
    chk("rst_hit_count", hit_count_o, 32'd0);
    chk("rst_miss_count", miss_count_o, 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready_o), 32'd0);

    // First load misses with a 3-cycle memory latency, then hits.
    mem_m[30'h401] = 32'hDEAD_BEEF;
    access(1'b0, 32'h0000_1004, '0, 3, 0, rd, rc);
    chk("ld_miss_reqcyc", 32'(rc), 32'd3);
    chk("ld_miss_rdata", rd, 32'hDEAD_BEEF);
    chk("ld_miss_count", miss_count_o, 32'd1);
    access(1'b0, 32'h0000_1004, '0, 3, 0, rd, rc);
    chk("ld_hit_reqcyc", 32'(rc), 32'd0);
    chk("ld_hit_rdata", rd, 32'hDEAD_BEEF);
    chk("ld_hit_count", hit_count_o, 32'd1);

    // Two-way replacement in set 1.
    do_reset();
    access(1'b0, 32'h1004, '0, 1, 0, rd, rc); chk("repl_1004_miss", 32'(rc != 0), 32'd1);
    access(1'b0, 32'h2004, '0, 2, 0, rd, rc); chk("repl_2004_miss", 32'(rc != 0), 32'd1);
    access(1'b0, 32'h3004, '0, 1, 0, rd, rc); chk("repl_3004_miss", 32'(rc != 0), 32'd1);
    access(1'b0, 32'h1004, '0, 1, 0, rd, rc); chk("repl_1004_again", 32'(rc != 0), 32'd1);
    access(1'b0, 32'h2004, '0, 1, 0, rd, rc); chk("repl_2004_again", 32'(rc != 0), 32'd1);
    access(1'b0, 32'h1004, '0, 1, 0, rd, rc); chk("repl_1004_hit", 32'(rc), 32'd0);
    access(1'b0, 32'h2004, '0, 1, 0, rd, rc); chk("repl_2004_hit", 32'(rc), 32'd0);
    access(1'b0, 32'h3004, '0, 1, 0, rd, rc); chk("repl_3004_evicted", 32'(rc != 0), 32'd1);
    chk("repl_miss_count", miss_count_o, 32'd6);
    chk("repl_hit_count", hit_count_o, 32'd2);

    // Store hit updates the line. Store miss does not allocate a line.
    access(1'b0, 32'h1004, '0, 1, 0, rd, rc);
    h0 = hit_count_o;
    m0 = miss_count_o;
    access(1'b1, 32'h1004, 32'h1234_5678, 2, 0, rd, rc);
    chk("st_reqcyc", 32'(rc), 32'd2);
    chk("st_mem_we", 32'(s_memwe), 32'd1);
    chk("st_mem_wdata", s_memwdata, 32'h1234_5678);
    chk("st_counters", hit_count_o + miss_count_o, h0 + m0);
    access(1'b0, 32'h1004, '0, 1, 0, rd, rc);
    chk("st_ld_hit", 32'(rc), 32'd0);
    chk("st_ld_rdata", rd, 32'h1234_5678);
    access(1'b1, 32'h5004, 32'hCAFE_F00D, 1, 0, rd, rc);
    access(1'b0, 32'h5004, '0, 1, 0, rd, rc);
    chk("st_noalloc_miss", 32'(rc != 0), 32'd1);
    chk("st_noalloc_rdata", rd, 32'hCAFE_F00D);

    // A flush with a request in the same cycle gives cpu_ready=0, and the next load misses.
    m0 = miss_count_o;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1004; flush_i = 1'b1;
    step();
    chk("flush_ready", 32'(s_ready), 32'd0);
    flush_i = 1'b0;
    access(1'b0, 32'h1004, '0, 1, 0, rd, rc);
    chk("flush_then_miss", 32'(rc != 0), 32'd1);
    chk("flush_miss_count", miss_count_o, m0 + 32'd1);

    // Reset in the middle of a read miss drops the transfer.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h7008; lat_g = 1000;
    step();
    step();
    set_rst(1'b1);
    step();
    set_rst(1'b0);
    cpu_req_i = 1'b0;
    chk("rstmid_mem_req", 32'(mem_req_o), 32'd0);
    chk("rstmid_hit_count", hit_count_o, 32'd0);
    chk("rstmid_miss_count", miss_count_o, 32'd0);
    access(1'b0, 32'h7008, '0, 2, 0, rd, rc);
    chk("rstmid_reload_miss", 32'(rc != 0), 32'd1);
    chk("rstmid_reload_cnt", miss_count_o, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        int n;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = rand_addr();
        lat_g = $urandom_range(1, 4);
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) step();
        set_rst(1'b1);
        step();
        set_rst(1'b0);
        cpu_req_i = 1'b0;
      end else if (r < 10) begin
        cpu_req_i = 1'b0;
        flush_i   = ($urandom_range(0, 1) == 1);
        step();
        flush_i   = 1'b0;
      end else begin
        access(($urandom_range(0, 9) < 3), rand_addr(), $urandom, $urandom_range(1, 4), 5,
               rd, rc);
      end
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
